bmm_mem_arbiter: RTL

//  Shares one single-port synchronous SRAM between the bmm core's instruction-fetch and data (LSU) ports.

---
 rtl/bmm_mem_pkg.sv | 32 +++
 rtl/bmm_mem_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bmm_mem_pkg.sv
// Shared types for the bmm instruction/data SRAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bmm_mem_pkg;

    // Which port owns the read response that is currently in flight.
    typedef enum logic [1:0] {
        RSP_IDLE  = 2'd0,
        RSP_INSTR = 2'd1,
        RSP_DATA  = 2'd2
    } rsp_port_e;

    // Response tag captured at grant time.
    // err marks an out-of-range read that must return ERR_RDATA.
    typedef struct packed {
        rsp_port_e port;
        logic      err;
    } rsp_tag_t;

    // Data returned for a read that never reached the SRAM.
    localparam logic [31:0] ERR_RDATA = 32'h0;

    // Tag value meaning that no response is in flight.
    localparam rsp_tag_t RSP_TAG_IDLE = '{port: RSP_IDLE, err: 1'b0};

    // Unsigned offset check.
    // An address below BASE_ADDR wraps to a huge offset and is rejected as well.
    function automatic logic addr_in_range(input logic [31:0] off, input logic [31:0] size);
        return off < size;
    endfunction

endpackage

// File: rtl/bmm_mem_arbiter.sv
// Shares one single-port SRAM between instruction-fetch and LSU ports, data has priority with a starvation guard.
// Latency: grant combinational in the request cycle; read data returned exactly 1 cycle after grant.
// Backpressure: a losing port sees gnt low and must hold its request; stores complete at grant with no response.
module bmm_mem_arbiter
    import bmm_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned NUM_BYTES  = 16384,
    parameter int unsigned MAX_STARVE = 4,
    localparam int unsigned AW        = $clog2(NUM_BYTES / 4)
) (
    input  logic          clk_i,
    input  logic          rst_ni,

    input  logic          instr_req_i,
    input  logic [31:0]   instr_addr_i,
    output logic          instr_gnt_o,
    output logic          instr_rvld_o,
    output logic [31:0]   instr_rdata_o,

    input  logic          data_req_i,
    input  logic [31:0]   data_addr_i,
    input  logic          data_we_i,
    input  logic [3:0]    data_be_i,
    input  logic [31:0]   data_wdata_i,
    output logic          data_gnt_o,
    output logic          data_rvalid_o,
    output logic [31:0]   data_rdata_o,
    output logic          data_err_o,

    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [3:0]    mem_be_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i
);

    localparam logic [31:0] MEM_SIZE    = 32'(NUM_BYTES);
    localparam logic [3:0]  STARVE_SATS = 4'(MAX_STARVE);

    // Byte offsets into the SRAM window and their range checks.
    logic [31:0] instr_off;
    logic [31:0] data_off;
    logic        instr_in_range;
    logic        data_in_range;

    assign instr_off      = instr_addr_i - BASE_ADDR;
    assign data_off       = data_addr_i - BASE_ADDR;
    assign instr_in_range = addr_in_range(instr_off, MEM_SIZE);
    assign data_in_range  = addr_in_range(data_off, MEM_SIZE);

    // Offset bits above the SRAM window are covered by the range check.
    // Offset bits [1:0] are ignored because accesses are word aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{instr_off[31:AW+2], instr_off[1:0],
                                data_off[31:AW+2], data_off[1:0]};

    // State: starvation counter and the in-flight response tag.
    logic [3:0] starve_cnt_q, starve_cnt_d;
    rsp_tag_t   rsp_tag_q, rsp_tag_d;

    logic instr_gnt;
    logic data_gnt;
    logic starve_hit;
    logic store_err;

    // Fixed-priority arbitration: data wins unless instr has lost MAX_STARVE times in a row.
    // Grants are held low while reset is asserted.
    always_comb begin
        instr_gnt  = 1'b0;
        data_gnt   = 1'b0;
        starve_hit = (starve_cnt_q == STARVE_SATS);
        if (rst_ni) begin
            if (data_req_i && !(instr_req_i && starve_hit)) begin
                data_gnt = 1'b1;
            end else if (instr_req_i) begin
                instr_gnt = 1'b1;
            end
        end
    end

    // Drive the SRAM from the winning port.
    // An out-of-range winner still gets its grant but never enables the macro.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = 32'h0;
        if (data_gnt) begin
            mem_en_o    = data_in_range;
            mem_we_o    = data_we_i & data_in_range;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_off[AW+1:2];
            mem_wdata_o = data_wdata_i;
        end else if (instr_gnt) begin
            mem_en_o    = instr_in_range;
            mem_be_o    = 4'hF;
            mem_addr_o  = instr_off[AW+1:2];
        end
    end

    // Count consecutive instr losses.
    // The count saturates at MAX_STARVE and clears on an instr win or when instr stops asking.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!instr_req_i || instr_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q != STARVE_SATS) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Remember which port a granted read belongs to, so its data can be steered next cycle.
    always_comb begin
        rsp_tag_d = RSP_TAG_IDLE;
        if (instr_gnt) begin
            rsp_tag_d = '{port: RSP_INSTR, err: !instr_in_range};
        end else if (data_gnt && !data_we_i) begin
            rsp_tag_d = '{port: RSP_DATA, err: !data_in_range};
        end
    end

    // State registers.
    // Asynchronous reset drops any in-flight response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_q <= 4'd0;
            rsp_tag_q    <= RSP_TAG_IDLE;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rsp_tag_q    <= rsp_tag_d;
        end
    end

    // A store that misses the SRAM window is flagged in its grant cycle.
    assign store_err = data_gnt & data_we_i & ~data_in_range;

    // Steer read data to the port named by the tag.
    // Unselected rdata outputs are held at zero.
    always_comb begin
        instr_rvld_o  = 1'b0;
        instr_rdata_o = 32'h0;
        data_rvalid_o = 1'b0;
        data_rdata_o  = 32'h0;
        data_err_o    = store_err;
        case (rsp_tag_q.port)
            RSP_INSTR: begin
                instr_rvld_o  = 1'b1;
                instr_rdata_o = rsp_tag_q.err ? ERR_RDATA : mem_rdata_i;
            end
            RSP_DATA: begin
                data_rvalid_o = 1'b1;
                data_rdata_o  = rsp_tag_q.err ? ERR_RDATA : mem_rdata_i;
                data_err_o    = store_err | rsp_tag_q.err;
            end
            default: ;
        endcase
    end

    assign instr_gnt_o = instr_gnt;
    assign data_gnt_o  = data_gnt;

endmodule
